// File: rtl/uart_rx_deserializer_if.sv
// UART receiver signal bundle: serial input plus enable from the loading
// controller side, delivered byte / counter / status back to it.
interface uart_rx_deserializer_if;
    logic       rxd;
    logic       rx_enable;
    logic [7:0] rhr_data;
    logic [7:0] rx_data_ready;
    logic       rx_valid;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    // Master drives the line and the enable, and consumes the results.
    modport master (
        output rxd,
        output rx_enable,
        input  rhr_data,
        input  rx_data_ready,
        input  rx_valid,
        input  frame_err,
        input  parity_err,
        input  busy
    );

    // Slave is the receiver itself.
    modport slave (
        input  rxd,
        input  rx_enable,
        output rhr_data,
        output rx_data_ready,
        output rx_valid,
        output frame_err,
        output parity_err,
        output busy
    );
endinterface

// File: rtl/uart_rx_deserializer.sv
// Serial-to-parallel UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is
// defined). Samples each bit at mid-bit using a single bit timer, validates
// start/stop (and parity), and publishes good bytes with a free-running
// 8-bit delivery counter that the downstream controller polls.
module uart_rx_deserializer #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic                    clk,
    input  logic                    reset,
    uart_rx_deserializer_if.slave   rx_if
);

    localparam int unsigned H    = CLKS_PER_BIT / 2;
    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);

    localparam logic [CntW-1:0] HalfLast = CntW'(H - 1);
    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StWaitIdle
    } state_e;

    // Synchronizer and sampled line.
    logic r_sync1;
    logic r_sync2;
    logic w_rs;

    // Frame state.
    state_e          r_state;
    logic [CntW-1:0] r_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;

    // Registered outputs.
    logic [7:0] r_rhr_data;
    logic [7:0] r_rx_data_ready;
    logic       r_rx_valid;
    logic       r_frame_err;
    logic       r_busy;

    logic w_half_end;
    logic w_bit_end;

`ifdef UART_RX_PARITY_EN
    logic r_par_bit;
    logic r_parity_err;
    logic w_par_ok;

    // Even parity: data bits plus the parity bit must XOR to zero.
    assign w_par_ok = ~(^{r_shift, r_par_bit});
`endif

    assign w_rs       = r_sync2;
    assign w_half_end = (r_cnt == HalfLast);
    assign w_bit_end  = (r_cnt == BitLast);

    // Two-flop synchronizer for the asynchronous line; resets to idle-high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_if.rxd;
            r_sync2 <= r_sync1;
        end
    end

    // Frame FSM with bit timer, shift register and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= StIdle;
            r_cnt           <= '0;
            r_bit_idx       <= '0;
            r_shift         <= '0;
            r_rhr_data      <= '0;
            r_rx_data_ready <= '0;
            r_rx_valid      <= 1'b0;
            r_frame_err     <= 1'b0;
            r_busy          <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bit       <= 1'b0;
            r_parity_err    <= 1'b0;
`endif
        end else begin
            // Pulses default low; busy lags the state by one cycle.
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= (r_state != StIdle);
            r_cnt       <= r_cnt + CntW'(1);
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif

            unique case (r_state)
                StIdle: begin
                    r_cnt <= '0;
                    if (!w_rs) begin
                        r_state <= StStart;
                    end
                end

                StStart: begin
                    if (w_half_end) begin
                        r_cnt <= '0;
                        if (!w_rs) begin
                            r_state   <= StData;
                            r_bit_idx <= '0;
                        end else begin
                            // Start bit gone by mid-bit: treat as a glitch.
                            r_state <= StIdle;
                        end
                    end
                end

                StData: begin
                    if (w_bit_end) begin
                        r_cnt     <= '0;
                        r_shift   <= {w_rs, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= StParity;
`else
                            r_state <= StStop;
`endif
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                StParity: begin
                    if (w_bit_end) begin
                        r_cnt     <= '0;
                        r_par_bit <= w_rs;
                        r_state   <= StStop;
                    end
                end
`endif

                StStop: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (!w_rs) begin
                            // Framing error wins over parity; byte discarded.
                            r_frame_err <= 1'b1;
                            r_state     <= StWaitIdle;
`ifdef UART_RX_PARITY_EN
                        end else if (!w_par_ok) begin
                            r_parity_err <= 1'b1;
                            r_state      <= StIdle;
`endif
                        end else begin
                            // Return at stop mid-bit so the next start edge is
                            // caught with no dead time.
                            r_state <= StIdle;
                            if (rx_if.rx_enable) begin
                                r_rhr_data      <= r_shift;
                                r_rx_data_ready <= r_rx_data_ready + 8'd1;
                                r_rx_valid      <= 1'b1;
                            end
                        end
                    end
                end

                StWaitIdle: begin
                    // Hold off until the line releases so a break cannot
                    // masquerade as a stream of frames.
                    r_cnt <= '0;
                    if (w_rs) begin
                        r_state <= StIdle;
                    end
                end

                default: begin
                    r_cnt   <= '0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign rx_if.rhr_data      = r_rhr_data;
    assign rx_if.rx_data_ready = r_rx_data_ready;
    assign rx_if.rx_valid      = r_rx_valid;
    assign rx_if.frame_err     = r_frame_err;
    assign rx_if.busy          = r_busy;
`ifdef UART_RX_PARITY_EN
    assign rx_if.parity_err    = r_parity_err;
`else
    assign rx_if.parity_err    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer at CLKS_PER_BIT=16.
module tb_uart_rx_deserializer;

    localparam int unsigned CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 155 + 16;
`else
    localparam int LAT = 155;
`endif

    logic clk;
    logic reset;

    uart_rx_deserializer_if u_if ();

    uart_rx_deserializer #(
        .CLKS_PER_BIT (CPB)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .rx_if (u_if)
    );

    int checks   = 0;
    int failures = 0;

    int cyc       = 0;
    int start_cyc = 0;
    int valid_cyc = 0;
    int valid_cnt = 0;
    int frame_cnt = 0;
    int par_cnt   = 0;
    int overlap   = 0;
    logic [7:0] rx_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (u_if.rx_valid === 1'b1) begin
            valid_cnt = valid_cnt + 1;
            valid_cyc = cyc;
            rx_q.push_back(u_if.rhr_data);
        end
        if (u_if.frame_err === 1'b1) frame_cnt = frame_cnt + 1;
        if (u_if.parity_err === 1'b1) par_cnt = par_cnt + 1;
        if ((32'(u_if.rx_valid) + 32'(u_if.frame_err) + 32'(u_if.parity_err)) > 1)
            overlap = overlap + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Caller is at a falling edge; returns at a falling edge after the stop bit.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
        u_if.rxd  = 1'b0;
        start_cyc = cyc;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            u_if.rxd = d[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        u_if.rxd = (^d) ^ par_flip;
        repeat (CPB) @(negedge clk);
`else
        if (par_flip) u_if.rxd = 1'b1;
`endif
        u_if.rxd = stop_bit;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".rhr"},   32'(u_if.rhr_data),      32'h00);
        check({tag, ".cnt"},   32'(u_if.rx_data_ready), 32'h00);
        check({tag, ".valid"}, 32'(u_if.rx_valid),      32'h0);
        check({tag, ".ferr"},  32'(u_if.frame_err),     32'h0);
        check({tag, ".perr"},  32'(u_if.parity_err),    32'h0);
        check({tag, ".busy"},  32'(u_if.busy),          32'h0);
    endtask

    int v0;
    int f0;

    initial begin
        reset       = 1'b1;
        u_if.rxd       = 1'b1;
        u_if.rx_enable = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Single byte with latency check.
        send_frame(8'hA5, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        check("a5.valid_cnt", 32'(valid_cnt), 32'd1);
        check("a5.rhr", 32'(u_if.rhr_data), 32'hA5);
        check("a5.cnt", 32'(u_if.rx_data_ready), 32'd1);
        check("a5.latency", 32'(valid_cyc - start_cyc), 32'(LAT));
        check("a5.busy_idle", 32'(u_if.busy), 32'd0);

        // Nine back-to-back bytes.
        rx_q.delete();
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        check("b2b.valid_cnt", 32'(valid_cnt), 32'd10);
        check("b2b.cnt", 32'(u_if.rx_data_ready), 32'd10);
        check("b2b.qsize", 32'(rx_q.size()), 32'd9);
        for (int i = 0; i < 9; i++) begin
            if (i < rx_q.size()) check("b2b.data", 32'(rx_q[i]), 32'(i + 1));
        end

        // Short low glitch: START entered then abandoned.
        v0 = valid_cnt;
        f0 = frame_cnt;
        u_if.rxd = 1'b0;
        repeat (5) @(negedge clk);
        check("glitch.busy_hi", 32'(u_if.busy), 32'd1);
        u_if.rxd = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch.busy_lo", 32'(u_if.busy), 32'd0);
        check("glitch.valid", 32'(valid_cnt), 32'(v0));
        check("glitch.ferr", 32'(frame_cnt), 32'(f0));
        check("glitch.cnt", 32'(u_if.rx_data_ready), 32'd10);

        // Framing error followed by a break, then a good frame.
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        check("ferr.count", 32'(frame_cnt), 32'(f0 + 1));
        check("ferr.no_valid", 32'(valid_cnt), 32'(v0));
        check("ferr.cnt", 32'(u_if.rx_data_ready), 32'd10);
        check("ferr.busy_wait", 32'(u_if.busy), 32'd1);
        u_if.rxd = 1'b1;
        repeat (16) @(negedge clk);
        check("ferr.busy_idle", 32'(u_if.busy), 32'd0);
        send_frame(8'h3C, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        check("ferr.good_valid", 32'(valid_cnt), 32'(v0 + 1));
        check("ferr.good_rhr", 32'(u_if.rhr_data), 32'h3C);
        check("ferr.good_cnt", 32'(u_if.rx_data_ready), 32'd11);
        check("ferr.single", 32'(frame_cnt), 32'(f0 + 1));

        // Counter wrap over 257 bytes, then a disabled frame.
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        v0 = valid_cnt;
        for (int i = 0; i < 257; i++) send_frame(i[7:0], 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        check("wrap.valid", 32'(valid_cnt), 32'(v0 + 257));
        check("wrap.cnt", 32'(u_if.rx_data_ready), 32'd1);
        check("wrap.rhr", 32'(u_if.rhr_data), 32'h00);
        u_if.rx_enable = 1'b0;
        v0 = valid_cnt;
        send_frame(8'h55, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        u_if.rx_enable = 1'b1;
        check("dis.valid", 32'(valid_cnt), 32'(v0));
        check("dis.cnt", 32'(u_if.rx_data_ready), 32'd1);
        check("dis.rhr", 32'(u_if.rhr_data), 32'h00);

        // Reset in the middle of data bit 4.
        u_if.rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            u_if.rxd = i[0];
            repeat (CPB) @(negedge clk);
        end
        u_if.rxd = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        check("mid.busy_pre", 32'(u_if.busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("midrst");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("mid.idle", 32'(u_if.busy), 32'd0);
        send_frame(8'h81, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        check("mid.rhr", 32'(u_if.rhr_data), 32'h81);
        check("mid.cnt", 32'(u_if.rx_data_ready), 32'd1);

`ifdef UART_RX_PARITY_EN
        // Wrong parity bit: pulse parity_err, no delivery.
        v0 = valid_cnt;
        f0 = par_cnt;
        send_frame(8'h81, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        check("par.perr", 32'(par_cnt), 32'(f0 + 1));
        check("par.valid", 32'(valid_cnt), 32'(v0));
        check("par.cnt", 32'(u_if.rx_data_ready), 32'd1);
`else
        check("par.never", 32'(par_cnt), 32'd0);
`endif

        check("pulse.overlap", 32'(overlap), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
